m_map_buffer_12: RTL and testbench
==================================

M_MAP_BUFFER_12 -- requirements
Module: m_map_buffer_12

Interface
REQ-001 SHALL have parameter num_in, default 13'd7744: feature-map words captured per frame.
REQ-002 SHALL have parameter addr_w, default 13: RAM address width; 2**addr_w >= num_in.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (asserted = 1), despite the name.
REQ-005 SHALL have port map_in, input, 16 bit signed: upstream conv result word.
REQ-006 SHALL have port save, input, 1 bit: map_in is valid this cycle.
REQ-007 SHALL have port map_out, output reg, 16 bit signed: word streamed to the next layer.
REQ-008 SHALL have port start, output reg, 1 bit: enables the next layer; map_out advances one word per cycle while high.
REQ-009 SHALL have port ready_in, input, 1 bit: downstream ready; 1 = still consuming, 0 = finished.
REQ-010 SHALL have port done, output reg, 1 bit: frame fully delivered downstream.

Function
REQ-011 SHALL implement states FILL, PRIME, STREAM, DONE; FILL is the reset state.
REQ-012 In FILL, each cycle with save=1 SHALL write map_in to RAM[wr_cnt] and increment wr_cnt; save=0 cycles SHALL leave wr_cnt unchanged (gaps allowed).
REQ-013 FILL SHALL go to PRIME on the cycle the write at wr_cnt==num_in-1 occurs; wr_cnt SHALL never exceed num_in-1.
REQ-014 save pulses outside FILL SHALL be ignored: no RAM write, no counter change.
REQ-015 PRIME SHALL last exactly one cycle, issuing the RAM read of address 0 (1-cycle read latency); start stays 0.
REQ-016 In STREAM, start SHALL be 1 and map_out SHALL be RAM[0], RAM[1], ..., RAM[num_in-1] on consecutive cycles, with RAM[0] appearing in the first cycle start=1.
REQ-017 After RAM[num_in-1], map_out SHALL be 0 while STREAM continues (pipeline flush); the read address SHALL saturate at num_in-1 and not wrap.
REQ-018 ready_in is sampled only in STREAM; ready_in=0 SHALL move to DONE on the next edge, including before all words are sent.
REQ-019 In DONE, start=0, map_out=0, done=1, held until reset; save and ready_in SHALL be ignored.
REQ-020 ready_in=0 during FILL or PRIME SHALL be ignored.
REQ-021 Data SHALL pass bit-exact; no arithmetic is applied.

Reset
REQ-022 While rst_n=1: state=FILL, wr_cnt=0, rd_addr=0, map_out=0, start=0, done=0; effective on the next edge.
REQ-023 Reset asserted mid-frame SHALL abort the frame; RAM contents need not be cleared and SHALL be overwritten by the next fill.
REQ-024 save=1 in the same cycle as rst_n=1 SHALL not write.

Structure
REQ-025 Constants SHALL live in a shared package or include file: data width 16, num_in per layer, state encodings.
REQ-026 Storage SHALL be one sub-module, m_map_ram: simple dual-port, 1 write port, 1 registered read port, 16 bit x 2**addr_w, inferable as block RAM.
REQ-027 The FSM, counters and output registers SHALL be in m_map_buffer_12; total RTL 120-400 lines.

Verification (num_in=4 unless noted)
REQ-028 Contiguous fill: save=1 for 4 cycles with 0x0001, 0xFFFF, 0x7FFF, 0x8000 -> PRIME for 1 cycle, then start=1 with map_out 0x0001, 0xFFFF, 0x7FFF, 0x8000, then 0x0000.
REQ-029 Gapped fill: save pattern 1,0,0,1,1,0,1 with words 10, 20, 30, 40 -> stream is exactly 10, 20, 30, 40; a 5th save after the 4th write is ignored.
REQ-030 Early termination: ready_in=0 on the 2nd STREAM cycle -> next cycle start=0, done=1, map_out=0; held for 100 cycles.
REQ-031 Reset mid-stream: rst_n=1 during STREAM -> next cycle all outputs 0, state FILL; a refill with 5, 6, 7, 8 streams 5, 6, 7, 8.
REQ-032 Full size: num_in=7744, ramp data 0..7743 with random save gaps -> 7744 in-order words, then zeros until ready_in=0; no wrap to word 0.
REQ-033 Ignored inputs: ready_in=0 throughout FILL and PRIME -> no early exit to DONE; the first STREAM cycle still has start=1.

Source files
------------

// File: rtl/m_map_buffer_12_pkg.sv
// Shared constants for the layer-12 feature-map buffer: data width, frame size, FSM states.
package m_map_buffer_12_pkg;

   localparam int DATA_W     = 16;
   localparam int NUM_IN_L12 = 7744;   // 88 x 88 output map of the preceding conv layer
   localparam int ADDR_W_L12 = 13;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/m_map_buffer_12_ram.sv
// Simple dual-port frame store: one write port, one registered read port (block-RAM style).
module m_map_ram
   import m_map_buffer_12_pkg::*;
#(
   parameter int addr_w = ADDR_W_L12
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [addr_w-1:0]        i_wr_addr,
   input  logic signed [DATA_W-1:0] i_wr_data,
   input  logic [addr_w-1:0]        i_rd_addr,
   output logic signed [DATA_W-1:0] o_rd_data
);

   logic signed [DATA_W-1:0] r_mem [2**addr_w];
   logic signed [DATA_W-1:0] r_rd_data;

   // Write port: no reset so the array maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Read port: one cycle of latency from address to data.
   always_ff @(posedge i_clk) begin
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/m_map_buffer_12.sv
// Captures one feature-map frame, then streams it in order to the next layer.
module m_map_buffer_12
   import m_map_buffer_12_pkg::*;
#(
   parameter int num_in = NUM_IN_L12,
   parameter int addr_w = ADDR_W_L12
) (
   input  logic                     clk_in,
   input  logic                     rst_n,      // active-high synchronous reset despite the name
   input  logic signed [DATA_W-1:0] map_in,
   input  logic                     save,
   output logic signed [DATA_W-1:0] map_out,
   output logic                     start,
   input  logic                     ready_in,
   output logic                     done
);

   localparam logic [addr_w-1:0] LAST = addr_w'(num_in - 1);
   localparam logic [addr_w-1:0] ONE  = addr_w'(1);

   state_t                   r_state;
   logic [addr_w-1:0]        r_wr_cnt;
   logic [addr_w-1:0]        r_rd_addr;
   logic                     r_out_vld;   // RAM read data currently holds a frame word
   logic                     r_last_rd;   // read of the final word has been issued
   logic                     r_start;
   logic                     r_done;
   logic                     w_we;
   logic signed [DATA_W-1:0] w_rd_data;

   // Writes only happen while filling; reset in the same cycle blocks the write.
   assign w_we = (r_state == ST_FILL) && save && !rst_n;

   m_map_ram #(.addr_w(addr_w)) u_ram (
      .i_clk     (clk_in),
      .i_we      (w_we),
      .i_wr_addr (r_wr_cnt),
      .i_wr_data (map_in),
      .i_rd_addr (r_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Frame FSM: fill counter, one-cycle read prime, saturating stream, sticky done.
   always_ff @(posedge clk_in) begin
      if (rst_n) begin
         r_state   <= ST_FILL;
         r_wr_cnt  <= '0;
         r_rd_addr <= '0;
         r_out_vld <= 1'b0;
         r_last_rd <= 1'b0;
         r_start   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (save) begin
                  if (r_wr_cnt == LAST) r_state  <= ST_PRIME;
                  else                  r_wr_cnt <= r_wr_cnt + ONE;
               end
            end
            ST_PRIME: begin
               // Address 0 is being read now; its data lands with the first start=1 cycle.
               r_state   <= ST_STREAM;
               r_start   <= 1'b1;
               r_out_vld <= 1'b1;
               r_last_rd <= (r_rd_addr == LAST);
               if (r_rd_addr != LAST) r_rd_addr <= r_rd_addr + ONE;
            end
            ST_STREAM: begin
               if (!ready_in) begin
                  r_state   <= ST_DONE;
                  r_start   <= 1'b0;
                  r_done    <= 1'b1;
                  r_out_vld <= 1'b0;
               end else begin
                  // Once the last word has been shown, output zeros instead of re-reading it.
                  if (r_last_rd) r_out_vld <= 1'b0;
                  if (r_rd_addr == LAST) r_last_rd <= 1'b1;
                  else                   r_rd_addr <= r_rd_addr + ONE;
               end
            end
            ST_DONE: ;
            default: r_state <= ST_FILL;
         endcase
      end
   end

   assign map_out = r_out_vld ? w_rd_data : '0;
   assign start   = r_start;
   assign done    = r_done;

endmodule

// File: tb/tb_m_map_buffer_12.sv
// Directed bench: small frame (num_in=4) scenarios, then a full 7744-word frame.
module tb_m_map_buffer_12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic               s_rst = 1'b1, s_save = 1'b0, s_rdy = 1'b1;
   logic signed [15:0] s_map = '0;
   logic signed [15:0] s_out;
   logic               s_start, s_done;

   // full-size instance
   logic               f_rst = 1'b1, f_save = 1'b0, f_rdy = 1'b1;
   logic signed [15:0] f_map = '0;
   logic signed [15:0] f_out;
   logic               f_start, f_done;

   int checks = 0;
   int failures = 0;

   m_map_buffer_12 #(.num_in(4), .addr_w(2)) u_small (
      .clk_in(clk), .rst_n(s_rst), .map_in(s_map), .save(s_save),
      .map_out(s_out), .start(s_start), .ready_in(s_rdy), .done(s_done)
   );

   m_map_buffer_12 u_full (
      .clk_in(clk), .rst_n(f_rst), .map_in(f_map), .save(f_save),
      .map_out(f_out), .start(f_start), .ready_in(f_rdy), .done(f_done)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d);
      s_save = 1'b1;
      s_map  = d;
      step();
      s_save = 1'b0;
   endtask

   task automatic do_rst();
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
   endtask

   // Checks four consecutive STREAM words, then one flush zero.
   task automatic expect_stream(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
      logic [15:0] e [4];
      e[0] = a; e[1] = b; e[2] = c; e[3] = d;
      for (int k = 0; k < 4; k++) begin
         chk("stream_start", 16'(s_start), 16'd1);
         chk("stream_word", s_out, e[k]);
         step();
      end
      chk("flush_word", s_out, 16'h0000);
      chk("flush_start", 16'(s_start), 16'd1);
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst_out", s_out, 16'h0);
      chk("rst_start", 16'(s_start), 16'd0);
      chk("rst_done", 16'(s_done), 16'd0);
      chk("rst_f_start", 16'(f_start), 16'd0);
      s_rst = 1'b0;
      f_rst = 1'b0;

      // contiguous fill
      wr(16'h0001); wr(16'hFFFF); wr(16'h7FFF); wr(16'h8000);
      chk("c_prime_start", 16'(s_start), 16'd0);
      step();
      expect_stream(16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000);
      step();
      chk("c_flush2", s_out, 16'h0000);
      s_rdy = 1'b0;
      step();
      chk("c_done", 16'(s_done), 16'd1);
      s_rdy = 1'b1;

      // gapped fill; saves in PRIME and STREAM must be ignored
      do_rst();
      wr(16'd10); step(); step(); wr(16'd20); wr(16'd30); step(); wr(16'd40);
      chk("g_prime_start", 16'(s_start), 16'd0);
      s_save = 1'b1; s_map = 16'd99;
      step();
      s_map = 16'd77;
      expect_stream(16'd10, 16'd20, 16'd30, 16'd40);
      s_save = 1'b0;
      step();
      chk("g_nowrap", s_out, 16'h0000);

      // ready_in low through FILL/PRIME ignored; early termination on 2nd STREAM cycle
      do_rst();
      s_rdy = 1'b0;
      wr(16'd1); step(); wr(16'd2); wr(16'd3); wr(16'd4);
      chk("e_prime_start", 16'(s_start), 16'd0);
      chk("e_prime_done", 16'(s_done), 16'd0);
      step();
      chk("e_c0_start", 16'(s_start), 16'd1);
      chk("e_c0_done", 16'(s_done), 16'd0);
      chk("e_c0_word", s_out, 16'd1);
      s_rdy = 1'b1;
      step();
      chk("e_c1_word", s_out, 16'd2);
      s_rdy = 1'b0;
      step();
      chk("e_done", 16'(s_done), 16'd1);
      chk("e_start", 16'(s_start), 16'd0);
      chk("e_out", s_out, 16'h0);
      s_rdy = 1'b1; s_save = 1'b1; s_map = 16'd55;
      for (int k = 0; k < 100; k++) begin
         step();
         chk("e_hold_done", 16'(s_done), 16'd1);
         chk("e_hold_start", 16'(s_start), 16'd0);
         chk("e_hold_out", s_out, 16'h0);
      end
      s_save = 1'b0;

      // reset mid-stream, then refill
      do_rst();
      wr(16'd11); wr(16'd12); wr(16'd13); wr(16'd14);
      step();
      chk("r_c0_word", s_out, 16'd11);
      step();
      chk("r_c1_word", s_out, 16'd12);
      s_rst = 1'b1; s_save = 1'b1; s_map = 16'd123;
      step();
      s_rst = 1'b0; s_save = 1'b0;
      chk("r_out", s_out, 16'h0);
      chk("r_start", 16'(s_start), 16'd0);
      chk("r_done", 16'(s_done), 16'd0);
      step();
      chk("r_idle_start", 16'(s_start), 16'd0);
      wr(16'd5); wr(16'd6); wr(16'd7); wr(16'd8);
      chk("r_prime_start", 16'(s_start), 16'd0);
      step();
      expect_stream(16'd5, 16'd6, 16'd7, 16'd8);

      // full-size frame: ramp with random gaps
      for (int i = 0; i < 7744; i++) begin
         repeat ($urandom_range(0, 2)) step();
         f_save = 1'b1;
         f_map  = 16'(i);
         step();
         f_save = 1'b0;
      end
      chk("f_prime_start", 16'(f_start), 16'd0);
      step();
      for (int i = 0; i < 7744; i++) begin
         chk("f_word", f_out, 16'(i));
         chk("f_start", 16'(f_start), 16'd1);
         step();
      end
      for (int k = 0; k < 3; k++) begin
         chk("f_flush", f_out, 16'h0);
         chk("f_flush_start", 16'(f_start), 16'd1);
         step();
      end
      f_rdy = 1'b0;
      step();
      chk("f_done", 16'(f_done), 16'd1);
      chk("f_done_start", 16'(f_start), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
